elastic_async_operator: RTL and testbench

Parametrised successor to the single-slot asynchronous dataflow operator. Each input gets a DEPTH-entry FIFO, and each consumer gets its own acknowledge (eager fork), so slow consumers no longer throttle fast ones beyond one result. The block sits between producer/operator nodes in generated `arf` dataflow graphs. It uses the same req/ack pull protocol: a node requests, and the upstream answers with a one-cycle ack carrying data.

---
 rtl/elastic_async_operator_if.sv | 13 +
 rtl/elastic_async_operator.sv | 78 +++++++
 tb/tb_elastic_async_operator.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/elastic_async_operator_if.sv
// elastic_async_operator_if: req/ack pull-protocol bundle; slave is the operator, master is its environment
interface elastic_async_operator_if #(
  parameter int DATA_WIDTH = 32,
  parameter int INPUT_SIZE = 2,
  parameter int OUTPUT_SIZE = 2
);
  logic [INPUT_SIZE-1:0] req_l, ack_l;
  logic [DATA_WIDTH*INPUT_SIZE-1:0] din;
  logic [OUTPUT_SIZE-1:0] req_r, ack_r;
  logic [DATA_WIDTH-1:0] dout;
  modport slave (output req_l, ack_r, dout, input ack_l, din, req_r);
  modport master (input req_l, ack_r, dout, output ack_l, din, req_r);
endinterface

// File: rtl/elastic_async_operator.sv
// elastic_async_operator: per-input FIFOs feeding an eager-fork dataflow operator; ELASTIC_OP_STATS_EN enables fire_count
module elastic_async_operator #(
  parameter int DATA_WIDTH = 32,
  parameter int INPUT_SIZE = 2,
  parameter int OUTPUT_SIZE = 2,
  parameter int DEPTH = 4,
  parameter string OP = "add",
  parameter logic [DATA_WIDTH-1:0] IMMEDIATE = '0
) (
  input  logic clk,
  input  logic rst,
  elastic_async_operator_if.slave bus,
  output logic [31:0] fire_count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  logic [DATA_WIDTH-1:0] head [INPUT_SIZE];
  logic [INPUT_SIZE-1:0] nonempty, req;
  logic [OUTPUT_SIZE-1:0] pending, ack, deliver;
  logic [DATA_WIDTH-1:0] res, dout_q;
  logic fire;
  assign fire = &nonempty && pending == '0;
  assign deliver = pending & bus.req_r & ~ack;
  assign bus.req_l = req;
  assign bus.ack_r = ack;
  assign bus.dout = dout_q;
  for (genvar i = 0; i < INPUT_SIZE; i++) begin : g_in
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic push, req_i;
    assign push = bus.ack_l[i];
    assign head[i] = mem[rp];
    assign nonempty[i] = cnt != '0;
    assign req[i] = req_i;
    // a raised request reserves a slot, so a push can never land in a full FIFO
    always_ff @(posedge clk)
      if (rst) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
        req_i <= 1'b0;
      end else begin
        if (push) mem[wp] <= bus.din[i*DATA_WIDTH +: DATA_WIDTH];
        wp <= push ? (wp == LAST ? '0 : wp + 1'b1) : wp;
        rp <= fire ? (rp == LAST ? '0 : rp + 1'b1) : rp;
        cnt <= cnt + CW'(push) - CW'(fire);
        req_i <= ~push & (req_i | (cnt - CW'(fire) < FULL));
      end
  end
  always_comb begin
    res = head[0];
    for (int k = 1; k < INPUT_SIZE; k++)
      res = OP == "add" ? res + head[k] : OP == "sub" ? res - head[k] : OP == "mul" ? res * head[k] : res;
    res = OP == "addi" ? head[0] + IMMEDIATE : OP == "subi" ? head[0] - IMMEDIATE :
          OP == "muli" ? head[0] * IMMEDIATE : res;
  end
  // fire only with nothing pending, so dout stays put until every consumer has sampled it
  always_ff @(posedge clk)
    if (rst) begin
      pending <= '0;
      ack <= '0;
      dout_q <= '0;
    end else begin
      pending <= fire ? '1 : pending & ~deliver;
      ack <= deliver;
      if (fire) dout_q <= res;
    end
`ifdef ELASTIC_OP_STATS_EN
  always_ff @(posedge clk)
    if (rst) fire_count <= '0;
    else if (fire) fire_count <= fire_count + 1'b1;
`else
  assign fire_count = '0;
`endif
endmodule

// File: tb/tb_elastic_async_operator.sv
// tb_elastic_async_operator: directed checks of elastic_async_operator across several parameterisations
module tb_elastic_async_operator;
  logic clk, rst;
  int cyc = 0, n_chk = 0, n_err = 0;
`ifdef ELASTIC_OP_STATS_EN
  localparam logic [31:0] FC_EXP = 32'd10;
`else
  localparam logic [31:0] FC_EXP = 32'd0;
`endif
  elastic_async_operator_if #(.DATA_WIDTH(32), .INPUT_SIZE(2), .OUTPUT_SIZE(2)) a_if ();
  elastic_async_operator_if #(.DATA_WIDTH(32), .INPUT_SIZE(1), .OUTPUT_SIZE(1)) i_if ();
  elastic_async_operator_if #(.DATA_WIDTH(32), .INPUT_SIZE(2), .OUTPUT_SIZE(1)) s_if ();
  elastic_async_operator_if #(.DATA_WIDTH(32), .INPUT_SIZE(2), .OUTPUT_SIZE(1)) m_if ();
  elastic_async_operator_if #(.DATA_WIDTH(32), .INPUT_SIZE(3), .OUTPUT_SIZE(1)) t_if ();
  logic [31:0] a_fc, i_fc, s_fc, m_fc, t_fc;
  elastic_async_operator #(.DATA_WIDTH(32), .INPUT_SIZE(2), .OUTPUT_SIZE(2), .DEPTH(4), .OP("add"))
    u_add (.clk(clk), .rst(rst), .bus(a_if), .fire_count(a_fc));
  elastic_async_operator #(.DATA_WIDTH(32), .INPUT_SIZE(1), .OUTPUT_SIZE(1), .DEPTH(3), .OP("addi"), .IMMEDIATE(32'd2))
    u_addi (.clk(clk), .rst(rst), .bus(i_if), .fire_count(i_fc));
  elastic_async_operator #(.DATA_WIDTH(32), .INPUT_SIZE(2), .OUTPUT_SIZE(1), .DEPTH(2), .OP("sub"))
    u_sub (.clk(clk), .rst(rst), .bus(s_if), .fire_count(s_fc));
  elastic_async_operator #(.DATA_WIDTH(32), .INPUT_SIZE(2), .OUTPUT_SIZE(1), .DEPTH(1), .OP("mul"))
    u_mul (.clk(clk), .rst(rst), .bus(m_if), .fire_count(m_fc));
  elastic_async_operator #(.DATA_WIDTH(32), .INPUT_SIZE(3), .OUTPUT_SIZE(1), .DEPTH(2), .OP("add"))
    u_add3 (.clk(clk), .rst(rst), .bus(t_if), .fire_count(t_fc));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  logic [31:0] qa0[$], qa1[$], qi[$], si_d[$];
  int si_e[$];
  int a_n0 = 0, a_n1 = 0, a_e0 = 0, a_e1 = 0, a_pe = 0;
  logic [31:0] a_d0 = 0, a_d1 = 0;
  logic [31:0] r_sub = 32'hDEADBEEF, r_mul = 32'hDEADBEEF, r_add3 = 32'hDEADBEEF;
  // upstream producers answer a request with a one-cycle ack; consumers log each ack_r pulse
  initial begin
    a_if.ack_l = '0; a_if.din = '0;
    i_if.ack_l = '0; i_if.din = '0;
    s_if.ack_l = '0; s_if.din = {32'd5, 32'd3};
    m_if.ack_l = '0; m_if.din = {32'h10000, 32'h10000};
    t_if.ack_l = '0; t_if.din = {32'd3, 32'd2, 32'd1};
    forever begin
      @(negedge clk);
      if (a_if.ack_r[0]) begin a_n0++; a_d0 = a_if.dout; a_e0 = cyc; end
      if (a_if.ack_r[1]) begin a_n1++; a_d1 = a_if.dout; a_e1 = cyc; end
      if (i_if.ack_r[0]) begin si_d.push_back(i_if.dout); si_e.push_back(cyc); end
      if (s_if.ack_r[0]) r_sub = s_if.dout;
      if (m_if.ack_r[0]) r_mul = m_if.dout;
      if (t_if.ack_r[0]) r_add3 = t_if.dout;
      a_if.ack_l[0] = a_if.req_l[0] && qa0.size() > 0;
      if (a_if.ack_l[0]) begin a_if.din[31:0] = qa0.pop_front(); a_pe = cyc + 1; end
      a_if.ack_l[1] = a_if.req_l[1] && qa1.size() > 0;
      if (a_if.ack_l[1]) begin a_if.din[63:32] = qa1.pop_front(); a_pe = cyc + 1; end
      i_if.ack_l[0] = i_if.req_l[0] && qi.size() > 0;
      if (i_if.ack_l[0]) i_if.din = qi.pop_front();
      s_if.ack_l = s_if.req_l;
      m_if.ack_l = m_if.req_l;
      t_if.ack_l = t_if.req_l;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic wait_n0(input int n);
    for (int t = 0; t < 200 && a_n0 < n; t++) tick();
    check("wait_ack0", a_n0, n);
  endtask
  task automatic wait_n1(input int n);
    for (int t = 0; t < 200 && a_n1 < n; t++) tick();
    check("wait_ack1", a_n1, n);
  endtask
  initial begin
    int t1;
    rst = 1;
    a_if.req_r = '0; i_if.req_r = '0; s_if.req_r = '0; m_if.req_r = '0; t_if.req_r = '0;
    repeat (3) tick();
    check("rst_req_l", 32'(a_if.req_l), 0);
    check("rst_ack_r", 32'(a_if.ack_r), 0);
    check("rst_dout", a_if.dout, 0);
    check("rst_fire_count", a_fc, 0);
    rst = 0;
    a_if.req_r = 2'b11; i_if.req_r = 1; s_if.req_r = 1; m_if.req_r = 1; t_if.req_r = 1;
    for (int k = 0; k < 20; k++) qi.push_back(32'(k));
    qa0.push_back(5); qa1.push_back(7);
    wait_n0(1);
    check("add_dout", a_d0, 12);
    check("add_latency", a_e0 - a_pe, 2);
    wait_n1(1);
    check("add_dout1", a_d1, 12);
    qa0.push_back(32'hFFFFFFFF); qa1.push_back(2);
    wait_n0(2);
    check("add_wrap", a_d0, 1);
    wait_n1(2);
    a_if.req_r = 2'b01;
    for (int k = 1; k <= 6; k++) begin qa0.push_back(32'(k)); qa1.push_back(32'(10 * k)); end
    wait_n0(3);
    check("fork_first", a_d0, 11);
    repeat (30) tick();
    check("fork_hold0", a_n0, 3);
    check("fork_hold1", a_n1, 2);
    check("fork_left0", qa0.size(), 1);
    check("fork_left1", qa1.size(), 1);
    check("fork_req_l", 32'(a_if.req_l), 0);
    a_if.req_r = 2'b11;
    wait_n1(3);
    check("fork_late", a_d1, 11);
    t1 = a_e1;
    wait_n0(4);
    check("fork_next", a_d0, 22);
    check("fork_next_gap", a_e0 - t1, 2);
    wait_n0(8);
    check("fork_drain", a_d0, 66);
    for (int t = 0; t < 200 && si_d.size() < 20; t++) tick();
    check("stream_cnt", si_d.size(), 20);
    for (int k = 0; k < si_d.size(); k++) check("stream", si_d[k], 32'(k + 2));
    if (si_e.size() >= 20) check("stream_rate", si_e[19] - si_e[10], 18);
    check("sub_wrap", r_sub, 32'hFFFFFFFE);
    check("mul_wrap", r_mul, 0);
    check("add3", r_add3, 6);
    a_if.req_r = 2'b00;
    for (int k = 0; k < 4; k++) begin qa0.push_back(32'(100 + k)); qa1.push_back(32'(200 + k)); end
    repeat (30) tick();
    check("mr_fill", qa0.size(), 0);
    rst = 1;
    tick();
    check("mr_req_l", 32'(a_if.req_l), 0);
    check("mr_ack_r", 32'(a_if.ack_r), 0);
    check("mr_dout", a_if.dout, 0);
    check("mr_fire_count", a_fc, 0);
    rst = 0;
    a_if.req_r = 2'b11;
    repeat (10) tick();
    check("mr_no_ack", a_n0, 8);
    qa0.push_back(8); qa1.push_back(9);
    wait_n0(9);
    check("mr_first", a_d0, 17);
    for (int k = 1; k <= 9; k++) begin qa0.push_back(32'(k)); qa1.push_back(32'(k)); end
    wait_n0(18);
    check("stats_last", a_d0, 18);
    check("fire_count", a_fc, FC_EXP);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish before 200000");
    $fatal(1);
  end
endmodule
